// File: rtl/ysyx_22050243_defs.sv
// Shared definitions for the ysyx_22050243 core: reset PC, instruction length
// and the fetch-unit state encoding.
package ysyx_22050243_defs;

  localparam logic [63:0] PC_START       = 64'h0000_0000_8000_0000;
  localparam int          INST_LEN_BYTES = 4;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22050243_ifu_if.sv
// Instruction-bus channel between the fetch unit (master) and instruction
// memory (slave): one request/response pair per fetch.
interface ysyx_22050243_ifu_if #(
  parameter int ADDR_WIDTH      = 64,
  parameter int IBUS_DATA_WIDTH = 32
);
  logic                       ireq_valid;
  logic                       ireq_ready;
  logic [ADDR_WIDTH-1:0]      ireq_addr;
  logic                       irsp_valid;
  logic [IBUS_DATA_WIDTH-1:0] irsp_data;
  logic                       irsp_err;

  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_ready, irsp_valid, irsp_data, irsp_err
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_ready, irsp_valid, irsp_data, irsp_err
  );
endinterface

// File: rtl/ysyx_22050243_pc_reg.sv
// Program counter: async reset to PC_START, redirect load takes priority over
// the sequential +4 step (which wraps modulo 2^ADDR_WIDTH).
module ysyx_22050243_pc_reg
  import ysyx_22050243_defs::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] PC_START   = ADDR_WIDTH'(ysyx_22050243_defs::PC_START)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_START;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(INST_LEN_BYTES);
    end
  end

endmodule

// File: rtl/ysyx_22050243_ifu.sv
// Instruction fetch unit: one outstanding instruction-bus read, registered
// {inst, pc, fault} towards decode, and redirect handling with wrong-path discard.
module ysyx_22050243_ifu
  import ysyx_22050243_defs::*;
#(
  parameter int                    ADDR_WIDTH      = 64,
  parameter int                    IBUS_DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_START        = ADDR_WIDTH'(ysyx_22050243_defs::PC_START)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_22050243_ifu_if.master        ibus,
  input  logic                       redirect_valid,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IBUS_DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic                       out_fault
);

  ifu_state_e            state_q, state_d;
  logic                  discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_inc;
  logic                  misaligned;
  logic                  req_hs;
  logic                  out_valid_d;
  logic                  load_rsp;
  logic                  load_fault;

  ysyx_22050243_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PC_START   (PC_START)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  // A misaligned pc never reaches the bus; it is reported as a fault instead.
  assign misaligned      = is_misaligned(pc[1:0]);
  assign ibus.ireq_valid = (state_q == IFU_REQ) && !misaligned;
  assign ibus.ireq_addr  = pc;
  assign req_hs          = ibus.ireq_valid && ibus.ireq_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IFU_IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    pc_inc      = 1'b0;
    out_valid_d = out_valid;
    load_rsp    = 1'b0;
    load_fault  = 1'b0;
    case (state_q)
      IFU_IDLE: state_d = IFU_REQ;
      IFU_REQ: begin
        // Redirect wins; an accepted request becomes a wrong-path fetch.
        if (redirect_valid) begin
          if (req_hs) begin
            discard_d = 1'b1;
            state_d   = IFU_WAIT;
          end
        end else if (misaligned) begin
          load_fault  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = IFU_OUT;
        end else if (req_hs) begin
          state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (ibus.irsp_valid) begin
          if (redirect_valid || discard_q) begin
            discard_d = 1'b0;
            state_d   = IFU_REQ;
          end else begin
            load_rsp    = 1'b1;
            pc_inc      = 1'b1;
            out_valid_d = 1'b1;
            state_d     = IFU_OUT;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      IFU_OUT: begin
        if (redirect_valid || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IFU_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      out_fault <= 1'b0;
    end else begin
      out_valid <= out_valid_d;
      if (load_rsp) begin
        out_inst  <= ibus.irsp_data;
        out_pc    <= pc;
        out_fault <= ibus.irsp_err;
      end else if (load_fault) begin
        out_inst  <= '0;
        out_pc    <= pc;
        out_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_ifu.sv
// Bench for ysyx_22050243_ifu: directed scenarios followed by random traffic,
// with a transaction-level fetch model and a simple instruction memory.
module tb_ysyx_22050243_ifu;
  import ysyx_22050243_defs::*;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam logic [63:0] START = 64'h0000_0000_8000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid, out_ready, out_fault;
  logic [DW-1:0] out_inst;
  logic [AW-1:0] out_pc;

  always #5 clk = ~clk;

  ysyx_22050243_ifu_if #(.ADDR_WIDTH(AW), .IBUS_DATA_WIDTH(DW)) ibus ();

  ysyx_22050243_ifu #(.ADDR_WIDTH(AW), .IBUS_DATA_WIDTH(DW), .PC_START(START)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ibus           (ibus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == START) return 32'h0000_0413;
    return (a[31:0] * 32'h9e37_79b1) ^ a[63:32];
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return a[6:2] == 5'h1f;
  endfunction

  // Reference state: address the next fetch must use; memory bookkeeping.
  logic [63:0] exp_pc;
  logic        mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;
  int          lat_min, lat_max;

  logic        prev_hold;
  logic [31:0] prev_inst;
  logic [63:0] prev_pc;
  logic        prev_fault;

  logic        cur_req, cur_ov, cur_fault;
  logic [63:0] cur_addr, cur_opc;
  logic [31:0] cur_inst;

  task automatic step(input logic rdy, input logic ordy, input logic rv, input logic [63:0] rpc);
    logic req_hs, mis;
    @(negedge clk);
    ibus.ireq_ready = rdy;
    out_ready       = ordy;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    if (mem_pend && mem_cnt == 0) begin
      ibus.irsp_valid = 1'b1;
      ibus.irsp_data  = mem_word(mem_addr);
      ibus.irsp_err   = mem_err(mem_addr);
    end else begin
      ibus.irsp_valid = 1'b0;
      ibus.irsp_data  = $urandom;
      ibus.irsp_err   = 1'($urandom_range(0, 1));
    end
    #1;
    cur_req   = ibus.ireq_valid;
    cur_addr  = ibus.ireq_addr;
    cur_ov    = out_valid;
    cur_opc   = out_pc;
    cur_inst  = out_inst;
    cur_fault = out_fault;

    if (prev_hold) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_pc", out_pc, prev_pc);
      check_eq("hold_inst", 64'(out_inst), 64'(prev_inst));
      check_eq("hold_fault", 64'(out_fault), 64'(prev_fault));
    end
    if (out_valid) check_eq("req_during_out", 64'(ibus.ireq_valid), 64'd0);
    if (ibus.ireq_valid) check_eq("req_while_outstanding", 64'(mem_pend), 64'd0);

    req_hs = ibus.ireq_valid && ibus.ireq_ready;
    if (req_hs) begin
      check_eq("req_addr", ibus.ireq_addr, exp_pc);
      check_eq("req_aligned", 64'(ibus.ireq_addr[1:0]), 64'd0);
    end
    if (out_valid && out_ready && !rv) begin
      mis = exp_pc[1:0] != 2'b00;
      check_eq("xfer_pc", out_pc, exp_pc);
      check_eq("xfer_inst", 64'(out_inst), mis ? 64'd0 : 64'(mem_word(exp_pc)));
      check_eq("xfer_fault", 64'(out_fault), 64'(mis | mem_err(exp_pc)));
      if (!mis) exp_pc = exp_pc + 64'd4;
    end
    if (rv) exp_pc = rpc;

    prev_hold  = out_valid && !out_ready && !rv;
    prev_pc    = out_pc;
    prev_inst  = out_inst;
    prev_fault = out_fault;

    if (ibus.irsp_valid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (req_hs) begin
      mem_pend = 1'b1;
      mem_addr = ibus.ireq_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
    end
  endtask

  initial begin
    logic found;
    logic [63:0] tgt;
    rst_n = 1'b0;
    ibus.ireq_ready = 1'b0; ibus.irsp_valid = 1'b0; ibus.irsp_data = '0; ibus.irsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    exp_pc = START; mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
    lat_min = 0; lat_max = 0; prev_hold = 1'b0;
    prev_pc = '0; prev_inst = '0; prev_fault = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_valid", 64'(ibus.ireq_valid), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_inst", 64'(out_inst), 64'd0);
    check_eq("rst_out_fault", 64'(out_fault), 64'd0);
    rst_n = 1'b1;

    // First fetch, zero-wait memory, decode stalled for 5 cycles.
    step(1, 0, 0, '0);
    check_eq("first_req_valid", 64'(cur_req), 64'd1);
    check_eq("first_req_addr", cur_addr, START);
    step(1, 0, 0, '0);
    check_eq("wait_out_valid", 64'(cur_ov), 64'd0);
    step(1, 0, 0, '0);
    check_eq("first_out_valid", 64'(cur_ov), 64'd1);
    check_eq("first_out_pc", cur_opc, START);
    check_eq("first_out_inst", 64'(cur_inst), 64'h0000_0413);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, '0);
      check_eq("stall_req", 64'(cur_req), 64'd0);
    end
    step(1, 1, 0, '0);
    lat_min = 3; lat_max = 3;
    step(1, 0, 0, '0);
    check_eq("second_req_valid", 64'(cur_req), 64'd1);
    check_eq("second_req_addr", cur_addr, START + 64'd4);

    // Redirect while waiting: pending response must be dropped.
    step(1, 0, 1, 64'h8000_0100);
    lat_min = 0; lat_max = 0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1, 1, 0, '0);
      check_eq("drop_out_valid", 64'(cur_ov), 64'd0);
      found = cur_req;
    end
    check_eq("redir_wait_found", 64'(found), 64'd1);
    check_eq("redir_wait_addr", cur_addr, 64'h8000_0100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1, 0, 0, '0);
      found = cur_ov;
    end
    check_eq("redir_wait_out_found", 64'(found), 64'd1);
    check_eq("redir_wait_out_pc", cur_opc, 64'h8000_0100);

    // Redirect in OUT together with out_ready: no transfer.
    step(1, 1, 1, 64'h8000_0200);
    step(1, 0, 0, '0);
    check_eq("redir_out_valid", 64'(cur_ov), 64'd0);
    check_eq("redir_out_req", 64'(cur_req), 64'd1);
    check_eq("redir_out_addr", cur_addr, 64'h8000_0200);

    // Misaligned target: fault without a bus request.
    step(1, 1, 1, 64'h8000_0102);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1, 0, 0, '0);
      check_eq("mis_no_req", 64'(cur_req), 64'd0);
      found = cur_ov;
    end
    check_eq("mis_found", 64'(found), 64'd1);
    check_eq("mis_fault", 64'(cur_fault), 64'd1);
    check_eq("mis_pc", cur_opc, 64'h8000_0102);
    check_eq("mis_inst", 64'(cur_inst), 64'd0);

    // Top-of-address-space fetch with access fault, then wrap to zero.
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1, 0, 0, '0);
      found = cur_ov;
    end
    check_eq("wrap_found", 64'(found), 64'd1);
    check_eq("wrap_fault", 64'(cur_fault), 64'd1);
    check_eq("wrap_out_pc", cur_opc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 1, 0, '0);
    step(1, 0, 0, '0);
    check_eq("wrap_req_valid", 64'(cur_req), 64'd1);
    check_eq("wrap_req_addr", cur_addr, 64'd0);

    // Random traffic against the reference model.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 4000; i++) begin
      logic rv;
      rv = $urandom_range(0, 99) < 4;
      case ($urandom_range(0, 5))
        0, 1, 2: tgt = START + {$urandom_range(0, 63), 2'b00};
        3:       tgt = START + {$urandom_range(0, 63), 2'b00} + 64'($urandom_range(1, 3));
        4:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
        default: tgt = 64'hFFFF_FFFF_FFFF_FFFC;
      endcase
      step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 60), rv, tgt);
    end

    // Asynchronous reset away from a clock edge clears state immediately.
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_req_valid", 64'(ibus.ireq_valid), 64'd0);
    check_eq("async_rst_out_pc", out_pc, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_ifu.md
Name: ysyx_22050243_ifu

Overview:
Instruction fetch unit, directly upstream of the decode stage that holds the immediate generator. Owns the PC, issues one instruction-memory read at a time over a valid/ready request channel, and captures the 32-bit response. Presents {inst, pc} to decode through a valid/ready output register. Accepts PC redirects from execute for jumps and taken branches, discarding wrong-path fetches.

Parameters:
ADDR_WIDTH, 64, PC and instruction-bus address width
IBUS_DATA_WIDTH, 32, instruction word width; matches decode's inst input
PC_START, 64'h0000_0000_8000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
ireq_valid  out  1  fetch request valid
ireq_ready  in  1  memory accepts request
ireq_addr  out  ADDR_WIDTH  fetch address; equals pc
irsp_valid  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance
irsp_data  in  IBUS_DATA_WIDTH  instruction word
irsp_err  in  1  access fault on this response
redirect_valid  in  1  execute redirect, single-cycle pulse
redirect_pc  in  ADDR_WIDTH  redirect target
out_valid  out  1  {inst, pc, fault} valid to decode
out_ready  in  1  decode accepts
out_inst  out  IBUS_DATA_WIDTH  fetched instruction
out_pc  out  ADDR_WIDTH  address of out_inst
out_fault  out  1  access fault or misaligned fetch

Behaviour:
- Reset: state=IDLE, pc=PC_START, discard=0, ireq_valid=0, out_valid=0, out_inst=0, out_pc=0, out_fault=0.
- States: IDLE, REQ, WAIT, OUT.
- IDLE: unconditionally -> REQ the next cycle, so the first request appears on the 2nd edge after reset release.
- REQ: ireq_valid=1, ireq_addr=pc, held stable until ireq_ready. On ireq_valid&ireq_ready -> WAIT.
- Misaligned pc (pc[1:0]!=0) in REQ: no request is issued. The unit loads out_valid=1, out_fault=1, out_pc=pc, out_inst=0 and goes -> OUT.
- WAIT: on irsp_valid:
  - discard=1: drop the response, clear discard -> REQ.
  - otherwise: out_inst=irsp_data, out_pc=pc, out_fault=irsp_err, out_valid=1, pc<=pc+4 -> OUT.
- pc+4 is modulo 2^ADDR_WIDTH; it wraps silently.
- OUT: hold all out_* stable while out_valid&~out_ready. On out_ready: out_valid<=0 -> REQ.
- Minimum latency is 3 cycles from request issue to out_valid, with a zero-wait memory (REQ, WAIT, OUT).
- Redirect has priority over every other event in the same cycle. In all cases pc<=redirect_pc.
  - IDLE: next state REQ.
  - REQ, no handshake this cycle: stay REQ with the new address; the address change is allowed because no request was accepted.
  - REQ, handshake this cycle: discard<=1 -> WAIT.
  - WAIT, irsp_valid low: discard<=1.
  - WAIT, irsp_valid high: drop the response -> REQ.
  - OUT: out_valid<=0 -> REQ, even if out_ready is high. Decode is flushed by the same pulse, so the transfer does not count.
- A redirect while discard=1 only updates pc. The single outstanding response is still dropped.
- Only one request is ever outstanding. ireq_valid=0 in WAIT and OUT.
- Asynchronous reset mid-transaction returns all state to reset values immediately. The memory side must also be reset; any late response is not tracked.

Decomposition:
- Shared package ysyx_22050243_defs (the existing define set) gains:
  - IFU state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, OUT=2'd3)
  - INST_LEN_BYTES=4
  - PC_START; the existing define is reused
- Sub-module ysyx_22050243_pc_reg: PC register with async reset to PC_START, load (redirect) and increment (+4) controls, load over increment.
- FSM, discard flag and output register stay in the top.

Test Plan:
- Reset release, ireq_ready=1, 1-cycle response 32'h00000413 -> ireq_addr=8000_0000. Outputs out_pc=8000_0000, out_inst=00000413, out_valid; next request at 8000_0004.
- out_ready held low 5 cycles -> out_* stable, ireq_valid=0 throughout. Raising out_ready gives exactly one transfer, then a request at pc+4.
- Redirect to 8000_0100 while in WAIT -> the pending response is dropped (out_valid stays 0). Next ireq_addr=8000_0100, and out_pc=8000_0100 on its response.
- Redirect to 8000_0200 in OUT with out_ready=1 in the same cycle -> out_valid falls. Next ireq_addr=8000_0200 and pc is not 8000_0004.
- Redirect to 8000_0102 -> no ireq_valid. Outputs out_valid=1, out_fault=1, out_pc=8000_0102.
- pc=FFFF_FFFF_FFFF_FFFC fetch with irsp_err=1 -> out_fault=1. Next ireq_addr=0000_0000_0000_0000.
